// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the TinyRISC hazard scoreboard: producer age, forward
// select and per-register tracking state.
package hazard_scoreboard_pkg;

  localparam int NREGS_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int RA        = NREGS_DEF - 1;

  // Position of the youngest in-flight writer of a register.
  localparam logic [1:0] AGE_IDLE = 2'd0;
  localparam logic [1:0] AGE_EX   = 2'd1;
  localparam logic [1:0] AGE_MA   = 2'd2;
  localparam logic [1:0] AGE_RW   = 2'd3;

  localparam logic [1:0] FWD_REG  = 2'd0;
  localparam logic [1:0] FWD_EXMA = 2'd1;
  localparam logic [1:0] FWD_MARW = 2'd2;

  typedef struct packed {
    logic [1:0] age;
    logic       isld;
  } reg_state_t;

  // Idle stays idle; RW wraps back to idle through the 2-bit overflow.
  function automatic logic [1:0] age_next(input logic [1:0] a);
    return (a == AGE_IDLE) ? AGE_IDLE : a + 2'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and interlock/forward response bundle for the scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREGS = 16,
  parameter int AW    = 4
);
  logic             id_valid;
  logic [AW-1:0]    id_rs1;
  logic [AW-1:0]    id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_wb;
  logic [AW-1:0]    id_rd;
  logic             id_is_ld;
  logic             flush;
  logic             pipe_hold;
  logic             stall;
  logic             issue;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [NREGS-1:0] busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wb, id_rd,
           id_is_ld, flush, pipe_hold,
    input  stall, issue, fwd_a, fwd_b, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wb, id_rd,
           id_is_ld, flush, pipe_hold,
    output stall, issue, fwd_a, fwd_b, busy
  );
endinterface

// File: rtl/hazard_scoreboard_sb_source_check.sv
// Hazard and forward-select decision for one ID source operand, given the
// tracked state of the register it reads.
module sb_source_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1
) (
  input  logic       use_src,
  input  logic [1:0] age,
  input  logic       isld,
  output logic       hazard,
  output logic [1:0] fwd
);

  always_comb begin
    hazard = 1'b0;
    fwd    = FWD_REG;
    if (use_src) begin
      if (FWD_EN != 0) begin
        // Only a load still in EX has no result latched yet.
        hazard = ((age == AGE_EX) && isld) ||
                 ((age == AGE_RW) && (RF_BYPASS == 0));
        case (age)
          AGE_EX:  fwd = FWD_EXMA;
          AGE_MA:  fwd = FWD_MARW;
          default: fwd = FWD_REG;
        endcase
      end else begin
        hazard = (age == AGE_EX) || (age == AGE_MA) ||
                 ((age == AGE_RW) && (RF_BYPASS == 0));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Interlock and forwarding controller at the ID/EX boundary: tracks in-flight
// register writes, stalls or issues the ID instruction, registers EX fwd selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS     = NREGS_DEF,
  parameter int AW        = AW_DEF,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1
) (
  input logic           clk,
  input logic           rst,
  hazard_scoreboard_if.slave sb
);

  reg_state_t [NREGS-1:0] st;
  reg_state_t             st_rs1;
  reg_state_t             st_rs2;
  logic                   haz_rs1;
  logic                   haz_rs2;
  logic [1:0]             sel_rs1;
  logic [1:0]             sel_rs2;
  logic                   front;
  logic                   stall_c;
  logic                   issue_c;
  logic [1:0]             fwd_a_q;
  logic [1:0]             fwd_b_q;
  logic [NREGS-1:0]       busy_v;

  assign st_rs1 = st[sb.id_rs1];
  assign st_rs2 = st[sb.id_rs2];

  sb_source_check #(.FWD_EN(FWD_EN), .RF_BYPASS(RF_BYPASS)) u_chk_rs1 (
    .use_src (sb.id_use_rs1),
    .age     (st_rs1.age),
    .isld    (st_rs1.isld),
    .hazard  (haz_rs1),
    .fwd     (sel_rs1)
  );

  sb_source_check #(.FWD_EN(FWD_EN), .RF_BYPASS(RF_BYPASS)) u_chk_rs2 (
    .use_src (sb.id_use_rs2),
    .age     (st_rs2.age),
    .isld    (st_rs2.isld),
    .hazard  (haz_rs2),
    .fwd     (sel_rs2)
  );

  // Flush and hold both mask the decision: a wrong-path or frozen ID slot
  // neither stalls nor allocates.
  assign front   = sb.id_valid && !sb.flush && !sb.pipe_hold;
  assign stall_c = front && (haz_rs1 || haz_rs2);
  assign issue_c = front && !stall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else if (!sb.pipe_hold) begin
      for (int r = 0; r < NREGS; r++) begin
        // The newest writer takes over the entry, superseding any older one.
        if (issue_c && sb.id_wb && (sb.id_rd == AW'(r))) begin
          st[r].age  <= AGE_EX;
          st[r].isld <= sb.id_is_ld;
        end else begin
          st[r].age  <= age_next(st[r].age);
        end
      end
      fwd_a_q <= issue_c ? sel_rs1 : FWD_REG;
      fwd_b_q <= issue_c ? sel_rs2 : FWD_REG;
    end
  end

  always_comb begin
    busy_v = '0;
    for (int r = 0; r < NREGS; r++) busy_v[r] = (st[r].age != AGE_IDLE);
  end

  assign sb.stall = stall_c;
  assign sb.issue = issue_c;
  assign sb.fwd_a = fwd_a_q;
  assign sb.fwd_b = fwd_b_q;
  assign sb.busy  = busy_v;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives three scoreboard configurations (fwd+bypass, fwd without bypass,
// no forwarding) against a pipeline-slot model plus hand-computed expectations.
module tb_hazard_scoreboard;

  localparam bit [2:0] FWD_CFG = 3'b011;  // bit k: dut k forwards
  localparam bit [2:0] BYP_CFG = 3'b101;  // bit k: dut k has write-through RF

  typedef struct packed {
    logic       valid;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u1;
    logic       u2;
    logic       wb;
    logic [3:0] rd;
    logic       ld;
    logic       flush;
    logic       hold;
  } stim_t;

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       ld;
  } slot_t;

  logic  clk;
  logic  rst;
  logic  chk_en;
  stim_t stim [3];

  logic [2:0]  o_stall;
  logic [2:0]  o_issue;
  logic [1:0]  o_fa   [3];
  logic [1:0]  o_fb   [3];
  logic [15:0] o_busy [3];

  int tests;
  int fails;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    hazard_scoreboard_if #(.NREGS(16), .AW(4)) bus ();
    assign bus.id_valid   = stim[k].valid;
    assign bus.id_rs1     = stim[k].rs1;
    assign bus.id_rs2     = stim[k].rs2;
    assign bus.id_use_rs1 = stim[k].u1;
    assign bus.id_use_rs2 = stim[k].u2;
    assign bus.id_wb      = stim[k].wb;
    assign bus.id_rd      = stim[k].rd;
    assign bus.id_is_ld   = stim[k].ld;
    assign bus.flush      = stim[k].flush;
    assign bus.pipe_hold  = stim[k].hold;

    hazard_scoreboard #(
      .NREGS(16), .AW(4),
      .FWD_EN(FWD_CFG[k] ? 1 : 0), .RF_BYPASS(BYP_CFG[k] ? 1 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus)
    );

    assign o_stall[k] = bus.stall;
    assign o_issue[k] = bus.issue;
    assign o_fa[k]    = bus.fwd_a;
    assign o_fb[k]    = bus.fwd_b;
    assign o_busy[k]  = bus.busy;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the writers currently sitting in the EX, MA and RW latches.
  slot_t      m_ex [3];
  slot_t      m_ma [3];
  slot_t      m_rw [3];
  logic [1:0] m_fa [3];
  logic [1:0] m_fb [3];

  function automatic int stage_of(int k, logic [3:0] s);
    if (m_ex[k].v && m_ex[k].rd == s) return 1;
    if (m_ma[k].v && m_ma[k].rd == s) return 2;
    if (m_rw[k].v && m_rw[k].rd == s) return 3;
    return 0;
  endfunction

  function automatic logic blocks(int k, logic u, logic [3:0] s);
    int st;
    st = stage_of(k, s);
    if (!u) return 1'b0;
    if (st == 3) return !BYP_CFG[k];
    if (FWD_CFG[k]) return (st == 1) && m_ex[k].ld;
    return (st == 1) || (st == 2);
  endfunction

  function automatic logic [1:0] exp_sel(int k, logic u, logic [3:0] s);
    int st;
    st = stage_of(k, s);
    if (!u || !FWD_CFG[k]) return 2'd0;
    if (st == 1) return 2'd1;
    if (st == 2) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic exp_stall(int k);
    return stim[k].valid && !stim[k].flush && !stim[k].hold &&
           (blocks(k, stim[k].u1, stim[k].rs1) || blocks(k, stim[k].u2, stim[k].rs2));
  endfunction

  function automatic logic exp_issue(int k);
    return stim[k].valid && !stim[k].flush && !stim[k].hold && !exp_stall(k);
  endfunction

  function automatic logic [15:0] exp_busy(int k);
    logic [15:0] b;
    b = '0;
    if (m_ex[k].v) b[m_ex[k].rd] = 1'b1;
    if (m_ma[k].v) b[m_ma[k].rd] = 1'b1;
    if (m_rw[k].v) b[m_rw[k].rd] = 1'b1;
    return b;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_ex[k] <= '0;
        m_ma[k] <= '0;
        m_rw[k] <= '0;
        m_fa[k] <= 2'd0;
        m_fb[k] <= 2'd0;
      end else if (!stim[k].hold) begin
        m_rw[k] <= m_ma[k];
        m_ma[k] <= m_ex[k];
        m_ex[k] <= (exp_issue(k) && stim[k].wb) ? slot_t'{1'b1, stim[k].rd, stim[k].ld} : '0;
        m_fa[k] <= exp_issue(k) ? exp_sel(k, stim[k].u1, stim[k].rs1) : 2'd0;
        m_fb[k] <= exp_issue(k) ? exp_sel(k, stim[k].u2, stim[k].rs2) : 2'd0;
      end
    end
  end

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check("stall", k, 32'(o_stall[k]), 32'(exp_stall(k)));
        check("issue", k, 32'(o_issue[k]), 32'(exp_issue(k)));
        check("fwd_a", k, 32'(o_fa[k]), 32'(m_fa[k]));
        check("fwd_b", k, 32'(o_fb[k]), 32'(m_fb[k]));
        check("busy",  k, 32'(o_busy[k]), 32'(exp_busy(k)));
      end
    end
  end

  function automatic stim_t ins(logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2,
                                logic u1, logic u2, logic wb, logic ld);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.u1 = u1; s.u2 = u2; s.wb = wb; s.ld = ld;
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) stim[k] = '0;
    repeat (4) cyc();
  endtask

  stim_t dep;

  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) stim[k] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", k, 32'(o_busy[k]), 32'h0);
      check("rst_fwd",  k, 32'({o_fa[k], o_fb[k]}), 32'h0);
    end
    rst = 1'b0;
    cyc();

    // ALU producer then dependent: no stall, fwd_a from EX/MA.
    stim[0] = ins(1, 2, 3, 1, 1, 1, 0); settle();
    check("alu_prod_issue", 0, 32'(o_issue[0]), 32'd1);
    cyc();
    stim[0] = ins(4, 1, 5, 1, 1, 1, 0); settle();
    check("alu_dep_stall", 0, 32'(o_stall[0]), 32'd0);
    check("alu_dep_issue", 0, 32'(o_issue[0]), 32'd1);
    cyc();
    stim[0] = '0; settle();
    check("alu_dep_fwd_a", 0, 32'(o_fa[0]), 32'd1);
    check("alu_dep_fwd_b", 0, 32'(o_fb[0]), 32'd0);
    drain();

    // Load-use: exactly one stall, then both operands from MA/RW.
    stim[0] = ins(1, 2, 0, 1, 0, 1, 1);
    cyc();
    stim[0] = ins(3, 1, 1, 1, 1, 1, 0); settle();
    check("ld_use_stall", 0, 32'(o_stall[0]), 32'd1);
    check("ld_use_noissue", 0, 32'(o_issue[0]), 32'd0);
    cyc();
    check("ld_retry_stall", 0, 32'(o_stall[0]), 32'd0);
    check("ld_retry_issue", 0, 32'(o_issue[0]), 32'd1);
    check("ld_bubble_fwd", 0, 32'(o_fa[0]), 32'd0);
    cyc();
    stim[0] = '0; settle();
    check("ld_fwd_a", 0, 32'(o_fa[0]), 32'd2);
    check("ld_fwd_b", 0, 32'(o_fb[0]), 32'd2);
    drain();

    // One instruction between producer and consumer: forward from MA/RW.
    stim[0] = ins(1, 2, 3, 1, 1, 1, 0);
    cyc();
    stim[0] = ins(6, 7, 8, 1, 1, 1, 0);
    cyc();
    stim[0] = ins(9, 1, 0, 1, 0, 1, 0); settle();
    check("gap1_issue", 0, 32'(o_issue[0]), 32'd1);
    cyc();
    stim[0] = '0; settle();
    check("gap1_fwd_a", 0, 32'(o_fa[0]), 32'd2);
    drain();

    // Two instructions between: producer in RW; bypass RF vs. one more stall.
    for (int k = 0; k < 2; k++) stim[k] = ins(1, 2, 3, 1, 1, 1, 0);
    cyc();
    for (int k = 0; k < 2; k++) stim[k] = ins(6, 7, 8, 1, 1, 1, 0);
    cyc();
    for (int k = 0; k < 2; k++) stim[k] = ins(10, 11, 12, 1, 1, 1, 0);
    cyc();
    for (int k = 0; k < 2; k++) stim[k] = ins(9, 1, 0, 1, 0, 1, 0);
    settle();
    check("rw_byp_stall", 0, 32'(o_stall[0]), 32'd0);
    check("rw_byp_issue", 0, 32'(o_issue[0]), 32'd1);
    check("rw_nobyp_stall", 1, 32'(o_stall[1]), 32'd1);
    cyc();
    stim[0] = '0; settle();
    check("rw_byp_fwd", 0, 32'(o_fa[0]), 32'd0);
    check("rw_nobyp_retry", 1, 32'(o_issue[1]), 32'd1);
    cyc();
    stim[1] = '0; settle();
    check("rw_nobyp_fwd", 1, 32'(o_fa[1]), 32'd0);
    drain();

    // Flush beats a load-use stall and the wrong-path op never allocates.
    stim[0] = ins(1, 2, 0, 1, 0, 1, 1);
    cyc();
    dep = ins(3, 1, 0, 1, 0, 1, 0);
    dep.flush = 1'b1;
    stim[0] = dep; settle();
    check("flush_stall", 0, 32'(o_stall[0]), 32'd0);
    check("flush_issue", 0, 32'(o_issue[0]), 32'd0);
    check("flush_busy", 0, 32'(o_busy[0]), 32'h0002);
    cyc();
    stim[0] = '0; settle();
    check("flush_busy_after", 0, 32'(o_busy[0]), 32'h0002);
    drain();

    // Pipeline hold freezes ages and fwd regs; dependent forwards on release.
    stim[0] = ins(2, 4, 5, 1, 1, 1, 0);
    cyc();
    stim[0] = ins(7, 2, 3, 1, 1, 1, 0); settle();
    check("hold_prod_issue", 0, 32'(o_issue[0]), 32'd1);
    cyc();
    dep = ins(8, 7, 7, 1, 1, 1, 0);
    dep.hold = 1'b1;
    stim[0] = dep;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_stall", 0, 32'(o_stall[0]), 32'd0);
      check("hold_issue", 0, 32'(o_issue[0]), 32'd0);
      check("hold_fwd_a", 0, 32'(o_fa[0]), 32'd1);
      check("hold_busy", 0, 32'(o_busy[0]), 32'h0084);
      cyc();
    end
    stim[0].hold = 1'b0; settle();
    check("hold_release_issue", 0, 32'(o_issue[0]), 32'd1);
    cyc();
    stim[0] = '0; settle();
    check("hold_release_fwd_a", 0, 32'(o_fa[0]), 32'd1);
    check("hold_release_fwd_b", 0, 32'(o_fb[0]), 32'd1);
    drain();

    // Younger load to the same rd owns the entry: load-use stall.
    stim[0] = ins(1, 2, 3, 1, 1, 1, 0);
    cyc();
    stim[0] = ins(1, 2, 0, 1, 0, 1, 1);
    cyc();
    stim[0] = ins(4, 1, 0, 1, 0, 1, 0); settle();
    check("waw_ld_stall", 0, 32'(o_stall[0]), 32'd1);
    cyc();
    check("waw_ld_issue", 0, 32'(o_issue[0]), 32'd1);
    cyc();
    stim[0] = '0; settle();
    check("waw_ld_fwd", 0, 32'(o_fa[0]), 32'd2);
    drain();

    // No forwarding: two stall cycles, then issue reading the RF.
    stim[2] = ins(1, 2, 3, 1, 1, 1, 0);
    cyc();
    stim[2] = ins(3, 1, 5, 1, 1, 1, 0); settle();
    check("nofwd_stall1", 2, 32'(o_stall[2]), 32'd1);
    cyc();
    check("nofwd_stall2", 2, 32'(o_stall[2]), 32'd1);
    cyc();
    check("nofwd_issue", 2, 32'(o_issue[2]), 32'd1);
    cyc();
    stim[2] = '0; settle();
    check("nofwd_fwd", 2, 32'(o_fa[2]), 32'd0);
    drain();

    // Reset in the middle of a stall clears tracking and drops the stall.
    stim[2] = ins(1, 2, 3, 1, 1, 1, 0);
    cyc();
    stim[2] = ins(3, 1, 5, 1, 1, 1, 0); settle();
    check("rst_mid_stall", 2, 32'(o_stall[2]), 32'd1);
    rst = 1'b1;
    cyc();
    check("rst_mid_busy", 2, 32'(o_busy[2]), 32'h0);
    check("rst_mid_nostall", 2, 32'(o_stall[2]), 32'd0);
    rst = 1'b0;
    stim[2] = '0;
    cyc();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised interlock and forwarding controller for the 5-stage TinyRISC pipeline (IF, ID, EX, MA, RW).
- Sits beside the ID/EX boundary. Tracks in-flight register writes per architectural register and decides, per ID instruction, whether to stall (bubble into EX) or issue.
- On issue, registers the EX-stage operand-forward selects.
- Replaces the current unprotected pipeline, which has no hazard handling; adds load-use stall, optional forwarding, pipeline hold and branch-flush handling.

Parameters:
NREGS, 16, number of architectural registers (ra = NREGS-1)
AW, 4, register address width, clog2(NREGS)
FWD_EN, 1, 1 = forward from EX/MA and MA/RW latches; 0 = stall until producer is in RW
RF_BYPASS, 1, 1 = register file is write-through (RW-stage producer counts as ready); 0 = stall one more cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  AW  resolved source 1 (after ret/st muxing)
id_rs2  in  AW  resolved source 2
id_use_rs1  in  1  source 1 read by the instruction
id_use_rs2  in  1  source 2 read by the instruction
id_wb  in  1  instruction writes a register
id_rd  in  AW  resolved destination (ra for call)
id_is_ld  in  1  instruction is a load
flush  in  1  branch taken in EX; ID instruction is wrong-path
pipe_hold  in  1  whole pipeline frozen this cycle (multicycle unit)
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX (combinational)
issue  out  1  ID instruction enters EX at this edge (combinational)
fwd_a  out  2  EX operand A source: 0 = reg, 1 = EX/MA aluResult, 2 = MA/RW result (registered)
fwd_b  out  2  EX operand B source, same encoding (registered)
busy  out  NREGS  per-register pending flag (debug)

Behaviour:
- Reset (synchronous, active-high, at clk edge): all ages = 0; ld flags = 0; fwd_a = fwd_b = 0. Reset also wins over a simultaneous issue.
- Per-register state:
  - age[1:0]: 0 = idle, 1 = producer in EX, 2 = in MA, 3 = in RW.
  - isld bit.
  - busy[r] = (age[r] != 0).
- Aging: each edge with !pipe_hold, every non-zero age increments; 3 wraps to 0.
- Hazard per used source s, evaluated on current state:
  - FWD_EN=1:
    - stall if age[s]==1 && isld[s] (load-use).
    - stall if age[s]==3 && !RF_BYPASS.
    - otherwise ready.
  - FWD_EN=0: stall if age[s] in {1,2}, or if age[s]==3 && !RF_BYPASS.
- Output logic:
  - stall = id_valid && !flush && !pipe_hold && (hazard on rs1 || hazard on rs2).
  - issue = id_valid && !flush && !pipe_hold && !stall.
  - flush dominates stall; the wrong-path ID instruction never allocates.
- On issue edge with id_wb:
  - age[id_rd] <= 1 and isld[id_rd] <= id_is_ld.
  - This overrides the aging of that register, so the youngest writer owns the entry.
  - Hazard evaluation uses pre-edge state, so rd == rs is legal.
- Forward select, computed at issue and registered into fwd_a/fwd_b:
  - age 1 → 1; age 2 → 2; age 0 or 3 → 0.
  - Unused source → 0. FWD_EN=0 → always 0.
- fwd regs on non-issue edges:
  - No issue (stall/flush/bubble) → fwd_a/fwd_b <= 0.
  - pipe_hold → fwd regs hold their value.
- Latency:
  - ALU producer → dependent issues next cycle with fwd=1, zero stall.
  - Load producer → exactly one stall cycle, then fwd=2.
- Two in-flight writers to the same rd: only the younger is tracked. The older one's completion does not clear the entry.

Decomposition:
- Shared package:
  - age encoding constants (AGE_IDLE/EX/MA/RW).
  - fwd encoding constants (FWD_REG/EXMA/MARW).
  - ra index constant.
- One sub-module, sb_source_check: per-source combinational hazard and fwd-select logic. Instantiated twice (rs1, rs2).

Test Plan:
- add r1 ← r2,r3 issued; next cycle sub r4 ← r1,r5 → stall=0, issue=1; next-cycle fwd_a=1, fwd_b=0.
- ld r1 ← [r2]; next cycle add r3 ← r1,r1 → stall=1 for exactly 1 cycle; then issue with fwd_a=fwd_b=2.
- add r1, then unrelated instruction, then use of r1 → fwd=2. A use one cycle later (age 3, RF_BYPASS=1) → fwd=0, no stall. With RF_BYPASS=0 → one stall.
- Dependent instruction stalled on load while flush=1 → stall=0, issue=0, no allocation; busy unchanged except aging.
- pipe_hold asserted 3 cycles after add r7 issue → age[7] frozen at 1, fwd regs held. After release, dependent sees fwd=1.
- FWD_EN=0: add r1, then dependent → 2 stall cycles, then issue with fwd=0. Reset mid-stall clears busy to 0 and drops stall next cycle.
